// File: rtl/sample_sequencer_pkg.sv
// Shared types and constants for the sample sequencer and its 1000-sample counter.
// Latency: none (types only); no flow control.
package sample_seq_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} seq_state_t;

  localparam int SAMPLE_TARGET = 1000;

endpackage

// File: rtl/sample_sequencer_if.sv
// Host and counter pins of the sample sequencer; slave is the sequencer side.
// Latency: wiring only; start is a level request, not a valid/ready handshake.
interface sample_sequencer_if #(
  parameter int DIV_WIDTH       = 8,
  parameter int BURST_CNT_WIDTH = 16
);
  logic                       start;
  logic                       abort;
  logic [DIV_WIDTH-1:0]       divisor;
  logic                       one_k_samples;
  logic                       cnt_up;
  logic                       clear;
  logic                       busy;
  logic                       done;
  logic [BURST_CNT_WIDTH-1:0] burst_count;

  modport slave (
    input  start, abort, divisor, one_k_samples,
    output cnt_up, clear, busy, done, burst_count
  );

  modport master (
    output start, abort, divisor, one_k_samples,
    input  cnt_up, clear, busy, done, burst_count
  );
endinterface

// File: rtl/sample_sequencer_strobe_divider.sv
// Prescaler that ticks once every 'period' enabled cycles; load restarts it at 0.
// Latency: tick is combinational from the registered count; en stalls the count.
module strobe_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             last;

  // period is never 0 here; the sequencer maps 0 to 1 before latching
  assign last = (cnt_q == period - WIDTH'(1));
  assign tick = en & last;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sample_sequencer.sv
// Drives the 1000-sample counter: clear, divided cnt_up strobes, then a done pulse.
// Latency: clear one cycle after start; done one cycle after one_k_samples; start ignored while busy.
module sample_sequencer
  import sample_seq_pkg::*;
#(
  parameter int DIV_WIDTH       = 8,
  parameter int BURST_CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  sample_sequencer_if.slave  bus
);
  seq_state_t                 state_q;
  logic [DIV_WIDTH-1:0]       div_q;
  logic [DIV_WIDTH-1:0]       div_d;
  logic [BURST_CNT_WIDTH-1:0] burst_count_q;
  logic                       tick;
  logic                       pre_load;
  logic                       pre_en;

  assign div_d    = (bus.divisor == '0) ? DIV_WIDTH'(1) : bus.divisor;
  assign pre_load = (state_q == CLEAR);
  assign pre_en   = (state_q == RUN);

  strobe_divider #(
    .WIDTH (DIV_WIDTH)
  ) u_strobe_divider (
    .clk    (clk),
    .n_rst  (n_rst),
    .load   (pre_load),
    .en     (pre_en),
    .period (div_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      div_q         <= DIV_WIDTH'(1);
      burst_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            div_q   <= div_d;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= bus.abort ? IDLE : RUN;
        end
        RUN: begin
          // abort wins so a burst cut short never reports completion
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (bus.one_k_samples) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (burst_count_q != '1) begin
            burst_count_q <= burst_count_q + BURST_CNT_WIDTH'(1);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // strobe suppressed in the cycle the burst ends so the counter never passes its target
  assign bus.cnt_up      = tick & ~bus.abort & ~bus.one_k_samples;
  assign bus.clear       = (state_q == CLEAR);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.burst_count = burst_count_q;
endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer with a behavioural 1000-sample counter attached.
module tb_sample_sequencer;
  import sample_seq_pkg::*;

  localparam int DW = 8;
  localparam int BW = 2;
  localparam int BC_MAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic force_flag = 1'b0;
  int unsigned k_cnt;

  int total = 0;
  int bad = 0;
  int model_bc = 0;
  int sb[$];

  always #5 clk = ~clk;

  sample_sequencer_if #(.DIV_WIDTH(DW), .BURST_CNT_WIDTH(BW)) bus ();

  sample_sequencer #(.DIV_WIDTH(DW), .BURST_CNT_WIDTH(BW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // counter on the far side of the interface
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      k_cnt <= 0;
    end else if (bus.clear) begin
      k_cnt <= 0;
    end else if (bus.cnt_up && k_cnt < SAMPLE_TARGET) begin
      k_cnt <= k_cnt + 1;
    end
  end
  assign bus.one_k_samples = (k_cnt == SAMPLE_TARGET) || force_flag;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one full burst starting from an IDLE cycle; returns in the IDLE cycle after done.
  task automatic run_burst(input int div_in, input int exp_div, input bit disturb, input bit hold);
    int   r;
    int   mism;
    int   strobes;
    int   budget;
    int   exp_bc;
    logic exp_cu;
    logic [DW-1:0] dv;
    dv = div_in[DW-1:0];
    bus.start   = 1'b1;
    bus.divisor = dv;
    step();
    if (!hold) bus.start = 1'b0;
    chk("clear_after_start", bus.clear, 1);
    chk("busy_in_clear", bus.busy, 1);
    exp_bc = (model_bc == BC_MAX) ? model_bc : model_bc + 1;
    model_bc = exp_bc;
    sb.push_back(exp_bc);
    step();
    chk("clear_one_cycle", bus.clear, 0);
    r = 0;
    mism = 0;
    strobes = 0;
    budget = 1000 * exp_div + 20;
    while (bus.one_k_samples !== 1'b1 && r < budget) begin
      if (disturb) begin
        if (r >= 10 && r <= 20) begin
          bus.start   = r[0];
          bus.divisor = 8'd2;
        end else begin
          bus.start = 1'b0;
        end
      end
      #1;
      exp_cu = ((r % exp_div) == exp_div - 1);
      if (bus.cnt_up !== exp_cu) mism++;
      if (bus.cnt_up === 1'b1) strobes++;
      step();
      r++;
    end
    if (disturb) bus.start = 1'b0;
    chk("flag_arrival_cycle", r, 1000 * exp_div);
    chk("strobe_count", strobes, SAMPLE_TARGET);
    chk("cnt_up_pattern_errors", mism, 0);
    #1;
    chk("cnt_up_off_on_flag", bus.cnt_up, 0);
    chk("no_done_on_flag", bus.done, 0);
    step();
    chk("done_pulse", bus.done, 1);
    chk("busy_in_done", bus.busy, 1);
    step();
    chk("done_one_cycle", bus.done, 0);
    chk("busy_fall", bus.busy, 0);
    chk("sb_pending", (sb.size() > 0), 1);
    if (sb.size() > 0) chk("burst_count", bus.burst_count, sb.pop_front());
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.divisor = '0;
    repeat (3) step();
    chk("rst_cnt_up", bus.cnt_up, 0);
    chk("rst_clear", bus.clear, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_burst_count", bus.burst_count, 0);
    n_rst = 1'b1;
    step();
    step();
    chk("idle_busy", bus.busy, 0);

    run_burst(4, 4, 1'b0, 1'b0);
    run_burst(0, 1, 1'b0, 1'b0);
    run_burst(1, 1, 1'b0, 1'b0);

    // abort on a strobe cycle deep in RUN
    bus.start = 1'b1;
    bus.divisor = 8'd4;
    step();
    bus.start = 1'b0;
    step();
    repeat (51) step();
    bus.abort = 1'b1;
    #1;
    chk("abort_cnt_up_off", bus.cnt_up, 0);
    step();
    bus.abort = 1'b0;
    chk("abort_idle", bus.busy, 0);
    chk("abort_no_done", bus.done, 0);
    step();
    chk("abort_no_done_late", bus.done, 0);
    chk("abort_count_kept", bus.burst_count, model_bc);

    // abort during CLEAR
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_clear_idle", bus.busy, 0);

    // abort and flag together
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    repeat (7) step();
    bus.abort = 1'b1;
    force_flag = 1'b1;
    #1;
    chk("abort_flag_cnt_up_off", bus.cnt_up, 0);
    step();
    bus.abort = 1'b0;
    force_flag = 1'b0;
    chk("abort_flag_idle", bus.busy, 0);
    chk("abort_flag_no_done", bus.done, 0);
    step();
    chk("abort_flag_no_done_late", bus.done, 0);
    chk("abort_flag_count_kept", bus.burst_count, model_bc);

    // start pulses and divisor change while running; count saturates here
    run_burst(4, 4, 1'b1, 1'b0);
    step();
    chk("start_not_queued", bus.busy, 0);
    chk("saturated_count", bus.burst_count, BC_MAX);

    // reset on a strobe cycle mid-RUN
    bus.start = 1'b1;
    bus.divisor = 8'd4;
    step();
    bus.start = 1'b0;
    step();
    repeat (19) step();
    n_rst = 1'b0;
    #1;
    chk("midrst_cnt_up", bus.cnt_up, 0);
    chk("midrst_clear", bus.clear, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_burst_count", bus.burst_count, 0);
    model_bc = 0;
    step();
    n_rst = 1'b1;
    step();
    run_burst(4, 4, 1'b0, 1'b0);

    // back-to-back with start held: second clear right after busy falls
    run_burst(2, 2, 1'b0, 1'b1);
    run_burst(2, 2, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
